// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, baud phase accumulator,
// frame sequencing and a first-word-fall-through receive FIFO.
module uart_rx_ctrl #(
    parameter int UART_SIZE    = 8,
    parameter int SYS_CLK_FREQ = 125000000,
    parameter int BAUD_RATE    = 115200,
    parameter int ACC_WIDTH    = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RX,
    input  logic                 cfg_parity_enable,
    input  logic                 cfg_parity_type,
    output logic                 parity_enable,
    output logic                 parity_type,
    output logic                 baud_tick,
    output logic                 phase_accum_reset,
    input  logic [UART_SIZE-1:0] rx_data,
    input  logic                 frame_valid,
    input  logic                 crc_error,
    input  logic                 stop_error,
    output logic                 RTS,
    input  logic                 rd_en,
    output logic [UART_SIZE+1:0] rd_data,
    output logic                 rd_empty,
    output logic                 overrun_err,
    output logic                 proto_err,
    input  logic                 err_clr
);

    localparam logic [63:0] INC_FULL =
        ((64'(BAUD_RATE) << ACC_WIDTH) + 64'(SYS_CLK_FREQ / 2))
        / 64'(SYS_CLK_FREQ);
    localparam logic [ACC_WIDTH-1:0] INC = INC_FULL[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] HALF =
        {1'b1, {(ACC_WIDTH-1){1'b0}}};

    localparam int BW = $clog2(UART_SIZE + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_DONE = 3'd5;

    logic [2:0]           state;
    logic [2:0]           state_nx;
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    logic                 rx_fall;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [BW-1:0]        bit_cnt;
    logic [1:0]           wait_cnt;
    logic                 push_req;
    logic                 timeout;
    logic                 stray;
    logic                 do_push;
    logic                 do_pop;
    logic                 full;
    logic                 empty;
    logic                 overrun;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nx;
    logic [UART_SIZE+1:0] mem [FIFO_DEPTH];

    // Sync flops reset low so a line already low after reset is no edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b0;
            rx_s2   <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;
    assign acc_sum = {1'b0, acc} + {1'b0, INC};

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (rx_fall) state_nx = START;
            START:
                if (baud_tick) state_nx = rx_s2 ? IDLE : DATA;
            DATA:
                if (baud_tick && bit_cnt == BW'(UART_SIZE - 1))
                    state_nx = parity_enable ? PARITY : STOP;
            PARITY:
                if (baud_tick) state_nx = STOP;
            STOP:
                if (baud_tick) state_nx = WAIT_DONE;
            WAIT_DONE:
                if (frame_valid || wait_cnt == 2'd3) state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    assign push_req = (state == WAIT_DONE) && frame_valid;
    assign stray    = (state != WAIT_DONE) && frame_valid;
    assign timeout  = (state == WAIT_DONE) && !frame_valid
                      && (wait_cnt == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            acc               <= '0;
            baud_tick         <= 1'b0;
            phase_accum_reset <= 1'b0;
            parity_enable     <= 1'b0;
            parity_type       <= 1'b0;
            bit_cnt           <= '0;
            wait_cnt          <= '0;
        end else begin
            state             <= state_nx;
            phase_accum_reset <= (state == IDLE) && rx_fall;
            if (state == IDLE && rx_fall) begin
                parity_enable <= cfg_parity_enable;
                parity_type   <= cfg_parity_type;
            end
            // Half-scale preload puts the carry in the middle of each bit
            if (state_nx == IDLE) begin
                acc       <= '0;
                baud_tick <= 1'b0;
            end else if (state == IDLE) begin
                acc       <= HALF;
                baud_tick <= 1'b0;
            end else begin
                acc       <= acc_sum[ACC_WIDTH-1:0];
                baud_tick <= acc_sum[ACC_WIDTH];
            end
            if (state != DATA)
                bit_cnt <= '0;
            else if (baud_tick)
                bit_cnt <= bit_cnt + BW'(1);
            if (state != WAIT_DONE)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 2'd1;
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = rd_en && !empty;
    assign do_push = push_req && (!full || do_pop);
    assign overrun = push_req && full && !do_pop;

    always_comb begin
        count_nx = count;
        unique case (1'b1)
            do_push && !do_pop: count_nx = count + CW'(1);
            do_pop && !do_push: count_nx = count - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            RTS    <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nx;
            RTS   <= (count_nx < CW'(FIFO_DEPTH - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= {crc_error, stop_error, rx_data};
    end

    assign rd_data  = empty ? '0 : mem[rd_ptr];
    assign rd_empty = empty;

    // A set event in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            overrun_err <= overrun | (overrun_err & ~err_clr);
            proto_err   <= timeout | stray | (proto_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at default parameters.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       RX = 1'b1;
    logic       cfg_parity_enable = 1'b0;
    logic       cfg_parity_type = 1'b0;
    logic       frame_valid = 1'b0;
    logic       crc_error = 1'b0;
    logic       stop_error = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       parity_enable;
    logic       parity_type;
    logic       baud_tick;
    logic       phase_accum_reset;
    logic       RTS;
    logic       rd_empty;
    logic       overrun_err;
    logic       proto_err;
    logic [9:0] rd_data;

    int checks = 0;
    int failures = 0;
    int t_cnt;
    int t_first;
    int t_gapbad;
    int t_pulses;
    int t_parbad;

    always #4 clk = ~clk;

    uart_rx_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .RX                (RX),
        .cfg_parity_enable (cfg_parity_enable),
        .cfg_parity_type   (cfg_parity_type),
        .parity_enable     (parity_enable),
        .parity_type       (parity_type),
        .baud_tick         (baud_tick),
        .phase_accum_reset (phase_accum_reset),
        .rx_data           (rx_data),
        .frame_valid       (frame_valid),
        .crc_error         (crc_error),
        .stop_error        (stop_error),
        .RTS               (RTS),
        .rd_en             (rd_en),
        .rd_data           (rd_data),
        .rd_empty          (rd_empty),
        .overrun_err       (overrun_err),
        .proto_err         (proto_err),
        .err_clr           (err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives a start edge and follows the frame until n ticks are seen
    task automatic run_ticks(input int n, input logic pe,
                             input logic pt, input logic flip);
        int cyc;
        int last;
        t_cnt = 0;
        t_first = 0;
        t_gapbad = 0;
        t_pulses = 0;
        t_parbad = 0;
        cyc = 0;
        last = 0;
        RX = 1'b0;
        while (t_cnt < n && cyc < 13000) begin
            @(negedge clk);
            cyc++;
            if (phase_accum_reset) t_pulses++;
            if (t_pulses > 0 &&
                (parity_enable !== pe || parity_type !== pt))
                t_parbad++;
            if (baud_tick) begin
                t_cnt++;
                if (t_cnt == 1) begin
                    t_first = cyc;
                    RX = 1'b1;
                end else if (cyc - last != 1085 && cyc - last != 1086) begin
                    t_gapbad++;
                end
                last = cyc;
                if (flip && t_cnt == 3) begin
                    cfg_parity_enable = ~cfg_parity_enable;
                    cfg_parity_type = ~cfg_parity_type;
                end
            end
        end
        chk("tick_count", 64'(t_cnt), 64'(n));
        chk("first_tick_window",
            64'(t_first >= 540 && t_first <= 550), 64'd1);
        chk("tick_spacing", 64'(t_gapbad), 64'd0);
        chk("resync_pulse", 64'(t_pulses), 64'd1);
        chk("parity_latched", 64'(t_parbad), 64'd0);
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (baud_tick) t_cnt++;
            if (phase_accum_reset) t_pulses++;
        end
    endtask

    task automatic push(input logic [7:0] d, input logic ce,
                        input logic se, input logic pop);
        rx_data = d;
        crc_error = ce;
        stop_error = se;
        frame_valid = 1'b1;
        rd_en = pop;
        @(negedge clk);
        frame_valid = 1'b0;
        rd_en = 1'b0;
        crc_error = 1'b0;
        stop_error = 1'b0;
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic frame(input logic [7:0] d, input logic ce,
                         input logic se, input logic pop);
        run_ticks(10, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        push(d, ce, se, pop);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_empty", 64'(rd_empty), 64'd1);
        chk("rst_rts", 64'(RTS), 64'd1);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_tick", 64'(baud_tick), 64'd0);
        chk("rst_resync", 64'(phase_accum_reset), 64'd0);
        chk("rst_parity", 64'({parity_enable, parity_type}), 64'd0);
        chk("rst_errs", 64'({overrun_err, proto_err}), 64'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        frame_valid = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        chk("stray_beats_clear", 64'(proto_err), 64'd1);
        chk("stray_no_push", 64'(rd_empty), 64'd1);
        @(negedge clk);
        err_clr = 1'b0;
        chk("proto_cleared", 64'(proto_err), 64'd0);

        frame(8'h65, 1'b0, 1'b0, 1'b1);
        chk("f1_not_empty", 64'(rd_empty), 64'd0);
        chk("f1_data", 64'(rd_data), 64'h065);
        chk("f1_rts", 64'(RTS), 64'd1);
        chk("f1_errs", 64'({overrun_err, proto_err}), 64'd0);

        t_cnt = 0;
        t_pulses = 0;
        RX = 1'b0;
        watch(325);
        RX = 1'b1;
        watch(1000);
        chk("glitch_ticks", 64'(t_cnt), 64'd1);
        chk("glitch_errs", 64'({overrun_err, proto_err}), 64'd0);
        chk("glitch_head", 64'(rd_data), 64'h065);

        cfg_parity_enable = 1'b1;
        cfg_parity_type = 1'b1;
        run_ticks(11, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        push(8'hA3, 1'b1, 1'b0, 1'b0);
        chk("f2_parity_hold", 64'({parity_enable, parity_type}), 64'd3);
        chk("f2_rts", 64'(RTS), 64'd1);

        frame(8'h3C, 1'b0, 1'b1, 1'b0);
        chk("f3_rts_low", 64'(RTS), 64'd0);
        chk("f3_no_ovr", 64'(overrun_err), 64'd0);
        frame(8'hF0, 1'b0, 1'b0, 1'b0);
        chk("f4_no_ovr", 64'(overrun_err), 64'd0);
        frame(8'h99, 1'b0, 1'b0, 1'b0);
        chk("f5_overrun", 64'(overrun_err), 64'd1);
        chk("f5_head", 64'(rd_data), 64'h065);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ovr_cleared", 64'(overrun_err), 64'd0);

        run_ticks(10, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("proto_early", 64'(proto_err), 64'd0);
        @(negedge clk);
        chk("proto_timeout", 64'(proto_err), 64'd1);
        chk("proto_no_ovr", 64'(overrun_err), 64'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("proto_cleared2", 64'(proto_err), 64'd0);

        frame(8'h5A, 1'b0, 1'b0, 1'b1);
        chk("full_pushpop_ovr", 64'(overrun_err), 64'd0);
        chk("pop1_data", 64'(rd_data), 64'h2A3);
        chk("full_rts", 64'(RTS), 64'd0);
        pop1();
        chk("pop2_data", 64'(rd_data), 64'h13C);
        pop1();
        chk("pop3_data", 64'(rd_data), 64'h0F0);
        pop1();
        chk("pop4_data", 64'(rd_data), 64'h05A);
        chk("one_left_rts", 64'(RTS), 64'd1);
        chk("one_left_empty", 64'(rd_empty), 64'd0);

        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        chk("stray_idle", 64'(proto_err), 64'd1);
        cfg_parity_enable = 1'b1;
        cfg_parity_type = 1'b0;
        run_ticks(4, 1'b1, 1'b0, 1'b0);
        RX = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_tick", 64'(baud_tick), 64'd0);
        chk("arst_parity", 64'({parity_enable, parity_type}), 64'd0);
        chk("arst_empty", 64'(rd_empty), 64'd1);
        chk("arst_data", 64'(rd_data), 64'd0);
        chk("arst_rts", 64'(RTS), 64'd1);
        chk("arst_errs", 64'({overrun_err, proto_err}), 64'd0);
        chk("arst_resync", 64'(phase_accum_reset), 64'd0);
        repeat (3) @(negedge clk);
        cfg_parity_enable = 1'b0;
        reset = 1'b1;

        t_cnt = 0;
        t_pulses = 0;
        watch(1200);
        chk("low_after_rst_ticks", 64'(t_cnt), 64'd0);
        chk("low_after_rst_resync", 64'(t_pulses), 64'd0);
        RX = 1'b1;
        repeat (5) @(negedge clk);
        pop1();
        chk("pop_empty_ignored", 64'(rd_empty), 64'd1);
        chk("pop_empty_data", 64'(rd_data), 64'd0);
        repeat (3) @(negedge clk);
        run_ticks(2, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameters: UART_SIZE, default 8, data bits per frame.
REQ-002 Parameters: SYS_CLK_FREQ, default 125000000, clk frequency in Hz.
REQ-003 Parameters: BAUD_RATE, default 115200, line rate in bps.
REQ-004 Parameters: ACC_WIDTH, default 32, phase accumulator width.
REQ-005 Parameters: FIFO_DEPTH, default 4, power of 2 and at least 2, receive FIFO entries.
REQ-006 Ports: clk, input, 1, the single clock; reset, input, 1, asynchronous active-low reset.
REQ-007 Ports: RX, input, 1, raw serial line, idle high, synchronised internally with 2 flops.
REQ-008 Ports: cfg_parity_enable and cfg_parity_type, inputs, 1 each, requested framing; parity_type 0 is odd and 1 is even.
REQ-009 Ports: parity_enable and parity_type, outputs, 1 each, framing driven to the rx datapath.
REQ-010 Ports: baud_tick, output, 1, one-cycle mid-bit sample strobe; phase_accum_reset, output, 1, one-cycle resync pulse.
REQ-011 Ports: rx_data, input, UART_SIZE, datapath result; frame_valid, input, 1, datapath frame-complete pulse; crc_error and stop_error, inputs, 1 each.
REQ-012 Ports: RTS, output, 1, high when ready to receive; rd_en, input, 1, FIFO pop.
REQ-013 Ports: rd_data, output, UART_SIZE+2, {crc_err, stop_err, data}; rd_empty, output, 1, FIFO empty flag.
REQ-014 Ports: overrun_err, output, 1, sticky overrun flag; proto_err, output, 1, sticky protocol error flag; err_clr, input, 1, clears both sticky flags.

Function
REQ-015 The increment SHALL be INC = round(BAUD_RATE * 2^ACC_WIDTH / SYS_CLK_FREQ), which is 3958242 at the defaults; the accumulator SHALL add INC modulo 2^ACC_WIDTH each cycle outside IDLE, and baud_tick SHALL equal the carry-out.
REQ-016 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_DONE.
REQ-017 In IDLE: the accumulator SHALL be held at 0 and baud_tick SHALL be 0.
REQ-018 On a synchronised RX falling edge in IDLE: the accumulator SHALL load 2^(ACC_WIDTH-1); phase_accum_reset SHALL pulse for 1 cycle; parity_enable and parity_type SHALL latch the cfg inputs; the FSM SHALL go to START.
REQ-019 At the first tick in START: if RX is high, the FSM SHALL return to IDLE as a false start and SHALL push nothing; otherwise it SHALL go to DATA.
REQ-020 In DATA: the FSM SHALL count UART_SIZE ticks, then go to PARITY if parity_enable is set, else to STOP.
REQ-021 PARITY SHALL last 1 tick and then go to STOP; STOP SHALL last 1 tick and then go to WAIT_DONE.
REQ-022 In WAIT_DONE: frame_valid SHALL trigger a push and a return to IDLE; if frame_valid is absent for 4 cycles, proto_err SHALL be set and the FSM SHALL return to IDLE.
REQ-023 frame_valid outside WAIT_DONE SHALL be ignored and SHALL set proto_err.
REQ-024 The latched parity outputs SHALL remain stable from the start edge until the return to IDLE; cfg changes mid-frame SHALL have no effect.
REQ-025 The FIFO SHALL be first-word-fall-through: rd_data shows the head entry when rd_empty is 0, the pop takes effect on the clk edge with rd_en high, and rd_en while empty SHALL be ignored.
REQ-026 A push when full SHALL drop the frame and set overrun_err.
REQ-027 A push and a pop in the same cycle while full SHALL both succeed, with no overrun.
REQ-028 A push and a pop in the same cycle while empty SHALL perform the push only.
REQ-029 RTS SHALL equal (count < FIFO_DEPTH-1) and be registered, so it deasserts one entry before full.
REQ-030 A simultaneous err_clr and error event SHALL leave the flag set.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-032 While reset is low: FSM in IDLE; accumulator, count and pointers at 0; baud_tick, phase_accum_reset, parity_enable, parity_type, overrun_err and proto_err at 0; rd_empty at 1; RTS at 1; rd_data at 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, with no push, and discard the FIFO contents.
REQ-034 After reset deasserts: RX low already present SHALL not start a frame until a high-to-low transition is seen.

Verification
REQ-035 Scenario: 8N1 frame 0x65 at defaults, frame_valid 2 cycles after the STOP tick -> baud_tick at about 542 cycles after the edge and then every 1085 or 1086 cycles; 10 ticks total; rd_data = {0,0,0x65}; rd_empty falls.
REQ-036 Scenario: 0.3-bit low glitch on RX -> 1 tick, return to IDLE, no push, no errors.
REQ-037 Scenario: cfg_parity_enable=1 with cfg_parity_type=1, then cfg toggled mid-frame -> 11 ticks; parity outputs stay 1/1 for the whole frame.
REQ-038 Scenario: 4 frames with no pops, then a 5th frame -> RTS falls after the 3rd push; the 5th frame is dropped and overrun_err=1; err_clr clears it; 4 pops return data in order.
REQ-039 Scenario: frame_valid withheld after STOP -> proto_err=1 after 4 cycles; FSM back in IDLE; next frame received normally.
REQ-040 Scenario: reset asserted during DATA -> all outputs at REQ-032 values asynchronously; no baud_tick until the next falling edge.
